// File: rtl/picorv_pkg.sv
// -----------------------------------------------------------------------------
// picorv_pkg
// Shared definitions for the two-master PicoRV32 native-memory arbiter.
//   arb_state_t   : arbiter FSM encoding (IDLE, GRANT0, GRANT1, RELEASE)
//   TIMEOUT_RDATA : read data returned to a requester whose transfer timed out
//   cnt_width()   : watchdog counter width, never narrower than 8 bits
// -----------------------------------------------------------------------------
package picorv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT0  = 2'd1,
        ST_GRANT1  = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    localparam logic [31:0] TIMEOUT_RDATA = 32'h0000_0000;

    // Wide enough to hold TIMEOUT, with an 8-bit floor.
    function automatic int cnt_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w > 8) ? w : 8;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Two-way round-robin selector.
//   req[1:0] : pending requests
//   last     : index of the previously granted requester
//   winner   : chosen requester; only meaningful when req != 0
// A lone requester always wins; on a tie the requester that was not granted
// last time wins.
// -----------------------------------------------------------------------------
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner
);

    assign winner = (&req) ? ~last : req[1];

endmodule

// File: rtl/picorv32_mem_arbiter.sv
// -----------------------------------------------------------------------------
// picorv32_mem_arbiter
// Arbitrates two PicoRV32 native memory masters (m0, m1) onto one downstream
// native port feeding the FreeAHB adapter.
//
// Ports
//   freeahb_clk, freeahb_resetn   : clock, async active-low reset
//   mX_mem_valid/instr/addr/wdata/wstrb : requester X transfer request
//   mX_mem_ready/rdata            : completion and read data back to X
//   s_mem_valid/instr/addr/wdata/wstrb  : downstream request
//   s_mem_ready/rdata             : downstream completion and read data
//   grant_id                      : current/last granted requester
//   timeout_err                   : one-cycle pulse when the watchdog fires
//
// Flow: IDLE picks a requester (round-robin on ties), GRANTx connects that
// requester straight through to the slave until completion, abandon or
// watchdog expiry, then RELEASE drops s_mem_valid for one cycle so the adapter
// always sees a gap between transfers.
// -----------------------------------------------------------------------------
module picorv32_mem_arbiter
    import picorv_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        freeahb_clk,
    input  logic        freeahb_resetn,

    input  logic        m0_mem_valid,
    input  logic        m0_mem_instr,
    input  logic [31:0] m0_mem_addr,
    input  logic [31:0] m0_mem_wdata,
    input  logic [3:0]  m0_mem_wstrb,
    output logic        m0_mem_ready,
    output logic [31:0] m0_mem_rdata,

    input  logic        m1_mem_valid,
    input  logic        m1_mem_instr,
    input  logic [31:0] m1_mem_addr,
    input  logic [31:0] m1_mem_wdata,
    input  logic [3:0]  m1_mem_wstrb,
    output logic        m1_mem_ready,
    output logic [31:0] m1_mem_rdata,

    output logic        s_mem_valid,
    output logic        s_mem_instr,
    output logic [31:0] s_mem_addr,
    output logic [31:0] s_mem_wdata,
    output logic [3:0]  s_mem_wstrb,
    input  logic        s_mem_ready,
    input  logic [31:0] s_mem_rdata,

    output logic        grant_id,
    output logic        timeout_err
);

    localparam int CW = cnt_width(TIMEOUT);
    // The watchdog fires in the TIMEOUT-th waiting cycle of a grant. The
    // counter is 0 in the first grant cycle, so that cycle is when it
    // holds TIMEOUT-1.
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam bit WD_EN = (TIMEOUT > 0);

    arb_state_t    state;
    logic          grant_q;
    logic [CW-1:0] wd_cnt;

    logic          in_grant;
    logic          sel1;
    logic          sel_valid;
    logic          done_ok;
    logic          done_to;
    logic          abandon;
    logic          winner;
    logic [31:0]   rdata_out;

    rr_pick2 u_rr_pick2 (
        .req    ({m1_mem_valid, m0_mem_valid}),
        .last   (grant_q),
        .winner (winner)
    );

    assign in_grant  = (state == ST_GRANT0) || (state == ST_GRANT1);
    assign sel1      = (state == ST_GRANT1);
    assign sel_valid = sel1 ? m1_mem_valid : m0_mem_valid;

    // A requester that drops valid mid-grant gets no completion, even if the
    // slave happens to finish in that same cycle. A real slave completion
    // beats a simultaneous watchdog expiry.
    assign abandon   = in_grant && !sel_valid;
    assign done_ok   = in_grant && sel_valid && s_mem_ready;
    assign done_to   = WD_EN && in_grant && sel_valid && !s_mem_ready &&
                       (wd_cnt == TO_LAST);

    assign rdata_out = done_to ? TIMEOUT_RDATA : s_mem_rdata;

    // Downstream request: straight pass-through from the granted requester,
    // forced to zero outside a grant.
    assign s_mem_valid = in_grant;
    assign s_mem_instr = in_grant && (sel1 ? m1_mem_instr : m0_mem_instr);
    assign s_mem_addr  = in_grant ? (sel1 ? m1_mem_addr  : m0_mem_addr)  : 32'h0;
    assign s_mem_wdata = in_grant ? (sel1 ? m1_mem_wdata : m0_mem_wdata) : 32'h0;
    assign s_mem_wstrb = in_grant ? (sel1 ? m1_mem_wstrb : m0_mem_wstrb) : 4'h0;

    // Upstream completion to the granted requester only.
    assign m0_mem_ready = (state == ST_GRANT0) && (done_ok || done_to);
    assign m1_mem_ready = (state == ST_GRANT1) && (done_ok || done_to);
    assign m0_mem_rdata = (state == ST_GRANT0) ? rdata_out : 32'h0;
    assign m1_mem_rdata = (state == ST_GRANT1) ? rdata_out : 32'h0;

    assign grant_id    = grant_q;
    assign timeout_err = done_to;

    always_ff @(posedge freeahb_clk or negedge freeahb_resetn) begin
        if (!freeahb_resetn) begin
            state   <= ST_IDLE;
            grant_q <= 1'b1;      // m0 wins the first tie after reset
            wd_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (m0_mem_valid || m1_mem_valid) begin
                        state   <= winner ? ST_GRANT1 : ST_GRANT0;
                        grant_q <= winner;
                        wd_cnt  <= '0;
                    end
                end
                ST_GRANT0, ST_GRANT1: begin
                    if (abandon || done_ok || done_to) begin
                        state <= ST_RELEASE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
